branch_resolve_unit: RTL and testbench

//  Tracks in-flight conditional branches between fetch and execute, wrapped around the 2-bit

---
 rtl/bp_pkg.sv | 7 +
 rtl/bp_pred_fifo.sv | 53 +++++
 rtl/branch_resolve_unit.sv | 111 +++++++++++
 tb/tb_branch_resolve_unit.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/bp_pkg.sv
// Shared defaults for the branch resolve unit and its prediction FIFO.
package bp_pkg;
  localparam int unsigned BP_DEPTH   = 4;
  localparam int unsigned BP_PTR_W   = 2;
  localparam int unsigned BP_CNT_W   = 16;
  localparam logic [BP_CNT_W-1:0] BP_CNT_MAX = '1;
endpackage

// File: rtl/bp_pred_fifo.sv
// DEPTH x 1-bit synchronous FIFO holding in-flight predictions in program order.
module bp_pred_fifo
  import bp_pkg::*;
#(
  parameter int unsigned DEPTH = BP_DEPTH,
  parameter int unsigned PTR_W = BP_PTR_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_push,
  input  logic             i_push_data,
  input  logic             i_pop,
  input  logic             i_flush,
  output logic [PTR_W:0]   o_count,
  output logic             o_head
);

  logic [DEPTH-1:0] r_mem;
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [PTR_W:0]   r_count;

  // Pointers wrap naturally because DEPTH == 2**PTR_W.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_mem    <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (i_push) begin
        r_mem[r_wr_ptr] <= i_push_data;
        r_wr_ptr        <= r_wr_ptr + PTR_W'(1);
      end
      if (i_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      case ({i_push, i_pop})
        2'b10:   r_count <= r_count + (PTR_W+1)'(1);
        2'b01:   r_count <= r_count - (PTR_W+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_count = r_count;
  assign o_head  = r_mem[r_rd_ptr];

endmodule

// File: rtl/branch_resolve_unit.sv
// Tracks in-flight branches around a 2-bit predictor: issues requests, stores predictions,
// resolves against execute outcomes, drives predictor updates, flushes on mispredict.
module branch_resolve_unit
  import bp_pkg::*;
#(
  parameter int unsigned DEPTH = BP_DEPTH,
  parameter int unsigned PTR_W = BP_PTR_W,
  parameter int unsigned CNT_W = BP_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_br_fetch,
  output logic             o_fetch_stall,
  output logic             o_pred_request,
  input  logic             i_pred_in,
  output logic             o_fetch_pred_vld,
  output logic             o_fetch_pred,
  input  logic             i_br_resolve,
  input  logic             i_br_taken,
  output logic             o_upd_result,
  output logic             o_upd_taken,
  output logic             o_mispredict,
  output logic             o_resolve_err,
  output logic [CNT_W-1:0] o_branch_cnt,
  output logic [CNT_W-1:0] o_mispred_cnt
);

  localparam logic [CNT_W-1:0] LP_CNT_MAX = '1;

  logic             r_pend;
  logic             r_fetch_pred_vld;
  logic             r_fetch_pred;
  logic             r_mispredict;
  logic             r_resolve_err;
  logic [CNT_W-1:0] r_branch_cnt;
  logic [CNT_W-1:0] r_mispred_cnt;

  logic [PTR_W:0]   w_count;
  logic [PTR_W:0]   w_occ;
  logic             w_head;
  logic             w_res_ok;
  logic             w_mis_now;
  logic             w_cap;
  logic             w_pop;

  // A pending request already owns a slot, so it counts toward occupancy.
  assign w_occ          = w_count + (PTR_W+1)'(r_pend);
  assign o_fetch_stall  = (w_occ == (PTR_W+1)'(DEPTH));
  assign w_res_ok       = i_br_resolve & (w_count != '0);
  assign w_mis_now      = w_res_ok & (i_br_taken != w_head);
  assign o_pred_request = i_br_fetch & ~o_fetch_stall & ~w_mis_now;
  assign w_cap          = r_pend & ~w_mis_now;
  assign w_pop          = w_res_ok & ~w_mis_now;
  assign o_upd_result   = w_res_ok;
  assign o_upd_taken    = w_res_ok & i_br_taken;

  bp_pred_fifo #(
    .DEPTH (DEPTH),
    .PTR_W (PTR_W)
  ) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .i_push      (w_cap),
    .i_push_data (i_pred_in),
    .i_pop       (w_pop),
    .i_flush     (w_mis_now),
    .o_count     (w_count),
    .o_head      (w_head)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pend           <= 1'b0;
      r_fetch_pred_vld <= 1'b0;
      r_fetch_pred     <= 1'b0;
      r_mispredict     <= 1'b0;
      r_resolve_err    <= 1'b0;
    end else begin
      r_pend           <= o_pred_request;
      r_fetch_pred_vld <= w_cap;
      if (w_cap) begin
        r_fetch_pred <= i_pred_in;
      end
      r_mispredict     <= w_mis_now;
      r_resolve_err    <= i_br_resolve & (w_count == '0);
    end
  end

  // Statistics saturate at all-ones rather than wrapping.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_branch_cnt  <= '0;
      r_mispred_cnt <= '0;
    end else begin
      if (w_res_ok && (r_branch_cnt != LP_CNT_MAX)) begin
        r_branch_cnt <= r_branch_cnt + CNT_W'(1);
      end
      if (w_mis_now && (r_mispred_cnt != LP_CNT_MAX)) begin
        r_mispred_cnt <= r_mispred_cnt + CNT_W'(1);
      end
    end
  end

  assign o_fetch_pred_vld = r_fetch_pred_vld;
  assign o_fetch_pred     = r_fetch_pred;
  assign o_mispredict     = r_mispredict;
  assign o_resolve_err    = r_resolve_err;
  assign o_branch_cnt     = r_branch_cnt;
  assign o_mispred_cnt    = r_mispred_cnt;

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Directed vector bench for branch_resolve_unit; a second instance with 2-bit counters
// shares the stimulus to observe saturation.
module tb_branch_resolve_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        br_fetch, pred_in, br_resolve, br_taken;

  logic        stall, req, vld, pred, upd, utk, mis, err;
  logic [15:0] bcnt, mcnt;
  logic        s_stall, s_req, s_vld, s_pred, s_upd, s_utk, s_mis, s_err;
  logic [1:0]  s_bcnt, s_mcnt;

  int n_vec  = 0;
  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  branch_resolve_unit u_dut (
    .clk(clk), .rst(rst), .i_br_fetch(br_fetch), .o_fetch_stall(stall),
    .o_pred_request(req), .i_pred_in(pred_in), .o_fetch_pred_vld(vld), .o_fetch_pred(pred),
    .i_br_resolve(br_resolve), .i_br_taken(br_taken), .o_upd_result(upd), .o_upd_taken(utk),
    .o_mispredict(mis), .o_resolve_err(err), .o_branch_cnt(bcnt), .o_mispred_cnt(mcnt)
  );

  branch_resolve_unit #(.CNT_W(2)) u_sat (
    .clk(clk), .rst(rst), .i_br_fetch(br_fetch), .o_fetch_stall(s_stall),
    .o_pred_request(s_req), .i_pred_in(pred_in), .o_fetch_pred_vld(s_vld), .o_fetch_pred(s_pred),
    .i_br_resolve(br_resolve), .i_br_taken(br_taken), .o_upd_result(s_upd), .o_upd_taken(s_utk),
    .o_mispredict(s_mis), .o_resolve_err(s_err), .o_branch_cnt(s_bcnt), .o_mispred_cnt(s_mcnt)
  );

  typedef struct {
    logic fetch, pin, res, tk;
    logic req, stall, upd, ut;
    logic vld, pred, mis, err;
    int   bc, mc;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic f, p, r, t, q, s, u, ut, v, pr, m, e,
                              input int bc, input int mc);
    vec_t x;
    x.fetch = f; x.pin = p; x.res = r; x.tk = t;
    x.req = q; x.stall = s; x.upd = u; x.ut = ut;
    x.vld = v; x.pred = pr; x.mis = m; x.err = e;
    x.bc = bc; x.mc = mc;
    return x;
  endfunction

  function automatic int sat3(input int v);
    return (v > 3) ? 3 : v;
  endfunction

  task automatic chk(input string name, input int idx, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s row %0d: got %0h expected %0h", name, idx, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    br_fetch = v.fetch; pred_in = v.pin; br_resolve = v.res; br_taken = v.tk;
  endtask

  task automatic compare(input vec_t v, input int idx);
    n_vec++;
    chk("pred_request", idx, 32'(req), 32'(v.req));
    chk("fetch_stall", idx, 32'(stall), 32'(v.stall));
    chk("upd_result", idx, 32'(upd), 32'(v.upd));
    chk("upd_taken", idx, 32'(utk), 32'(v.ut));
    chk("fetch_pred_vld", idx, 32'(vld), 32'(v.vld));
    chk("fetch_pred", idx, 32'(pred), 32'(v.pred));
    chk("mispredict", idx, 32'(mis), 32'(v.mis));
    chk("resolve_err", idx, 32'(err), 32'(v.err));
    chk("branch_cnt", idx, 32'(bcnt), 32'(v.bc));
    chk("mispred_cnt", idx, 32'(mcnt), 32'(v.mc));
    chk("sat_branch_cnt", idx, 32'(s_bcnt), 32'(sat3(v.bc)));
    chk("sat_mispred_cnt", idx, 32'(s_mcnt), 32'(sat3(v.mc)));
  endtask

  task automatic apply(input vec_t v, input int idx);
    @(negedge clk);
    drive(v);
    #1;
    compare(v, idx);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    //            fe pi re tk  rq st up ut  vl pr mi er  bc mc
    // fill: four requests, stall once slots and pending request reach DEPTH
    vecs.push_back(mk(1, 1, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(1, 1, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(1, 1, 0, 0, 1, 0, 0, 0, 1, 1, 0, 0, 0, 0));
    vecs.push_back(mk(1, 1, 0, 0, 1, 0, 0, 0, 1, 1, 0, 0, 0, 0));
    vecs.push_back(mk(1, 1, 0, 0, 0, 1, 0, 0, 1, 1, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 1, 0, 0, 1, 1, 0, 0, 0, 0));
    // drain four correct taken resolves
    vecs.push_back(mk(0, 0, 1, 1, 0, 1, 1, 1, 0, 1, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 1, 1, 0, 0, 1, 1, 0, 1, 0, 0, 1, 0));
    vecs.push_back(mk(0, 0, 1, 1, 0, 0, 1, 1, 0, 1, 0, 0, 2, 0));
    vecs.push_back(mk(0, 0, 1, 1, 0, 0, 1, 1, 0, 1, 0, 0, 3, 0));
    // three predictions {1,0,1}, resolved correctly
    vecs.push_back(mk(1, 0, 0, 0, 1, 0, 0, 0, 0, 1, 0, 0, 4, 0));
    vecs.push_back(mk(1, 1, 0, 0, 1, 0, 0, 0, 0, 1, 0, 0, 4, 0));
    vecs.push_back(mk(1, 0, 0, 0, 1, 0, 0, 0, 1, 1, 0, 0, 4, 0));
    vecs.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 4, 0));
    vecs.push_back(mk(0, 0, 1, 1, 0, 0, 1, 1, 1, 1, 0, 0, 4, 0));
    vecs.push_back(mk(0, 0, 1, 0, 0, 0, 1, 0, 0, 1, 0, 0, 5, 0));
    vecs.push_back(mk(0, 0, 1, 1, 0, 0, 1, 1, 0, 1, 0, 0, 6, 0));
    // three predictions of 1, head mispredicts, then resolve on empty
    vecs.push_back(mk(1, 0, 0, 0, 1, 0, 0, 0, 0, 1, 0, 0, 7, 0));
    vecs.push_back(mk(1, 1, 0, 0, 1, 0, 0, 0, 0, 1, 0, 0, 7, 0));
    vecs.push_back(mk(1, 1, 0, 0, 1, 0, 0, 0, 1, 1, 0, 0, 7, 0));
    vecs.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 7, 0));
    vecs.push_back(mk(0, 0, 1, 0, 0, 0, 1, 0, 1, 1, 0, 0, 7, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 8, 1));
    vecs.push_back(mk(0, 0, 1, 1, 0, 0, 0, 0, 0, 1, 0, 0, 8, 1));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 8, 1));
    // pending capture and fetch collide with a mispredict
    vecs.push_back(mk(1, 0, 0, 0, 1, 0, 0, 0, 0, 1, 0, 0, 8, 1));
    vecs.push_back(mk(1, 0, 0, 0, 1, 0, 0, 0, 0, 1, 0, 0, 8, 1));
    vecs.push_back(mk(1, 1, 1, 1, 0, 0, 1, 1, 1, 0, 0, 0, 8, 1));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 9, 2));
    // resolve while only a request is pending
    vecs.push_back(mk(1, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 9, 2));
    vecs.push_back(mk(0, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 9, 2));
    vecs.push_back(mk(0, 0, 1, 1, 0, 0, 1, 1, 1, 1, 0, 1, 9, 2));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 10, 2));
    // capture and correct resolve in the same cycle
    vecs.push_back(mk(1, 0, 0, 0, 1, 0, 0, 0, 0, 1, 0, 0, 10, 2));
    vecs.push_back(mk(1, 0, 0, 0, 1, 0, 0, 0, 0, 1, 0, 0, 10, 2));
    vecs.push_back(mk(0, 1, 1, 0, 0, 0, 1, 0, 1, 0, 0, 0, 10, 2));
    vecs.push_back(mk(0, 0, 1, 1, 0, 0, 1, 1, 1, 1, 0, 0, 11, 2));
    vecs.push_back(mk(0, 0, 1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 12, 2));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 12, 2));

    // reset held two cycles
    rst = 1'b1;
    drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    compare(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), 999);

    foreach (vecs[i]) apply(vecs[i], i);

    // reset mid-stream with one entry stored and a fetch during reset
    apply(mk(1, 0, 0, 0, 1, 0, 0, 0, 0, 1, 0, 0, 12, 2), 100);
    apply(mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 12, 2), 101);
    @(negedge clk);
    rst = 1'b1;
    drive(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    @(negedge clk);
    rst = 1'b0;
    drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    #1;
    compare(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), 102);
    apply(mk(0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), 103);
    apply(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0), 104);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
